// File: rtl/lift_pkg.sv
// Shared types and constants for the 5/3 lifting-step datapath.
package lift_pkg;
  localparam int W     = 16;
  localparam int CNT_W = 4;

  typedef logic signed [W-1:0] sample_t;

  localparam logic HIPASS = 1'b1;
  localparam logic FWD    = 1'b1;
endpackage

// File: rtl/lift_step_unit_if.sv
// Sequencer-facing sample bus. The master presents operands and mode bits;
// the slave returns the registered lifted sample.
interface lift_step_unit_if #(parameter int W = 16);
  // ex is a one-way qualifier with no ready: the slave loads res_s on every
  // rising edge where ex=1, so the master may change operands every cycle.
  logic signed [W-1:0] l_s;
  logic signed [W-1:0] r_s;
  logic signed [W-1:0] s_s;
  logic                lohipass;
  logic                fwd_inv;
  logic                ex;
  logic signed [W-1:0] res_s;

  modport master (output l_s, r_s, s_s, lohipass, fwd_inv, ex, input res_s);
  modport slave  (input l_s, r_s, s_s, lohipass, fwd_inv, ex, output res_s);
endinterface

// File: rtl/lift_alu.sv
// Combinational 5/3 lifting arithmetic: neighbour-sum, rounding shift, add/sub.
module lift_alu
  import lift_pkg::*;
#(
  parameter int W = 16
) (
  input  logic signed [W-1:0] l_s,
  input  logic signed [W-1:0] r_s,
  input  logic signed [W-1:0] s_s,
  input  logic                lohipass,
  input  logic                fwd_inv,
  output logic signed [W-1:0] res
);
  localparam logic signed [W+1:0] RND = 2;

  logic signed [W+1:0] sum;
  logic signed [W+1:0] d;
  logic signed [W+1:0] s_ext;
  logic signed [W+1:0] wide;
  logic                sub;

  // Predict subtracts on the forward pass; update adds on the forward pass,
  // which is what makes each inverse step undo its forward twin exactly.
  always_comb begin
    sum   = {{2{l_s[W-1]}}, l_s} + {{2{r_s[W-1]}}, r_s};
    s_ext = {{2{s_s[W-1]}}, s_s};
    d     = (lohipass == HIPASS) ? (sum >>> 1) : ((sum + RND) >>> 2);
    sub   = (lohipass == HIPASS) ? (fwd_inv == FWD) : (fwd_inv != FWD);
    wide  = sub ? (s_ext - d) : (s_ext + d);
    res   = wide[W-1:0];
  end
endmodule

// File: rtl/lift_cnt.sv
// Free-running wrap-around cycle counter, held at zero while clr is high.
module lift_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l)  q <= '0;
    else if (clr)  q <= '0;
    else           q <= q + 1'b1;
  end
endmodule

// File: rtl/lift_rst_sync.sv
// Reset conditioner: asynchronous assert, RST_STAGES-edge synchronous release.
module lift_rst_sync #(
  parameter int RST_STAGES = 2
) (
  input  logic clk,
  input  logic reset_l,
  output logic rst_o
);
  logic [RST_STAGES-1:0] sync;

  // Ones drain out of the chain from the bottom; rst_o is the last stage.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) sync <= '1;
    else          sync <= sync << 1;
  end

  assign rst_o = sync[RST_STAGES-1];
endmodule

// File: rtl/lift_step_unit.sv
// 5/3 lifting-step unit: result register, cycle counter and reset conditioner.
module lift_step_unit
  import lift_pkg::*;
#(
  parameter int W          = lift_pkg::W,
  parameter int CNT_W      = lift_pkg::CNT_W,
  parameter int RST_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_l,
  lift_step_unit_if.slave   bus,
  output logic [CNT_W-1:0]  q,
  output logic              rst_o
);
  logic signed [W-1:0] alu_res;

  lift_rst_sync #(.RST_STAGES(RST_STAGES)) u_rst_sync (
    .clk     (clk),
    .reset_l (reset_l),
    .rst_o   (rst_o)
  );

  lift_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .reset_l (reset_l),
    .clr     (rst_o),
    .q       (q)
  );

  lift_alu #(.W(W)) u_alu (
    .l_s      (bus.l_s),
    .r_s      (bus.r_s),
    .s_s      (bus.s_s),
    .lohipass (bus.lohipass),
    .fwd_inv  (bus.fwd_inv),
    .res      (alu_res)
  );

  // reset_l clears immediately; rst_o keeps the register at zero until release completes.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l)     bus.res_s <= '0;
    else if (rst_o)   bus.res_s <= '0;
    else if (bus.ex)  bus.res_s <= alu_res;
  end
endmodule

// File: tb/tb_lift_step_unit.sv
// Directed and random stimulus for lift_step_unit with an expected-value queue.
module tb_lift_step_unit;
  import lift_pkg::*;

  logic       clk = 1'b0;
  logic       reset_l;
  logic [3:0] q;
  logic       rst_o;

  lift_step_unit_if #(.W(16)) bus ();

  lift_step_unit dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus),
    .q       (q),
    .rst_o   (rst_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Independent reference: integer arithmetic with the 5/3 sign convention.
  function automatic logic [15:0] model(input sample_t l, input sample_t r, input sample_t s,
                                        input logic lo, input logic fw);
    int sum, d, res;
    bit sub;
    sum = int'(l) + int'(r);
    if (lo) d = sum >>> 1;
    else    d = (sum + 2) >>> 2;
    sub = lo ? fw : !fw;
    res = sub ? int'(s) - d : int'(s) + d;
    return res[15:0];
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge; drives, lets one rising edge load, checks at the next falling edge.
  task automatic step(input string tag, input sample_t l, input sample_t r, input sample_t s,
                      input logic lo, input logic fw, input logic ex, input logic [15:0] exp_v);
    logic [15:0] got;
    bus.l_s = l; bus.r_s = r; bus.s_s = s;
    bus.lohipass = lo; bus.fwd_inv = fw; bus.ex = ex;
    if (ex) last_exp = exp_v;
    exp_q.push_back(last_exp);
    @(posedge clk);
    @(negedge clk);
    got = exp_q.pop_front();
    chk(tag, {16'h0, bus.res_s}, {16'h0, got});
  endtask

  task automatic rand_ops(output sample_t l, output sample_t r, output sample_t s);
    l = sample_t'($urandom_range(0, 65535));
    r = sample_t'($urandom_range(0, 65535));
    s = sample_t'($urandom_range(0, 65535));
  endtask

  // ---------------- sequence ----------------
  initial begin
    sample_t l, r, s;
    logic lo, fw, ex;
    reset_l = 1'b0;
    last_exp = '0;
    bus.l_s = '0; bus.r_s = '0; bus.s_s = '0;
    bus.lohipass = 1'b0; bus.fwd_inv = 1'b0; bus.ex = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_res", {16'h0, bus.res_s}, 32'd0);
    chk("rst_q", {28'h0, q}, 32'd0);
    chk("rst_o_held", {31'h0, rst_o}, 32'd1);

    reset_l = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_o_edge1", {31'h0, rst_o}, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("rst_o_edge2", {31'h0, rst_o}, 32'd0);
    chk("q_edge2", {28'h0, q}, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("q_count%0d", i), {28'h0, q}, 32'(i % 16));
    end

    step("hp_fwd",  16'sd10, 16'sd20, 16'sd100, HIPASS, FWD,  1'b1, 16'd85);
    step("hp_inv",  16'sd10, 16'sd20, 16'sd85,  HIPASS, !FWD, 1'b1, 16'd100);
    step("lp_fwd", -16'sd8,  16'sd4,  16'sd50,  !HIPASS, FWD,  1'b1, 16'd49);
    step("lp_inv", -16'sd8,  16'sd4,  16'sd49,  !HIPASS, !FWD, 1'b1, 16'd50);

    step("hold_load", 16'sd10, 16'sd20, 16'sd100, HIPASS, FWD, 1'b1, 16'd85);
    for (int i = 0; i < 5; i++) begin
      rand_ops(l, r, s);
      step($sformatf("hold%0d", i), l, r, s, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b0, 16'd85);
    end

    step("wrap_pos", 16'sd2, 16'sd2, 16'sd32767, HIPASS, !FWD, 1'b1, 16'h8001);
    step("wrap_neg", 16'sd2, 16'sd2, -16'sd32768, HIPASS, FWD, 1'b1, 16'd32766);

    for (int i = 0; i < 24; i++) begin
      rand_ops(l, r, s);
      lo = 1'($urandom_range(0, 1));
      fw = 1'($urandom_range(0, 1));
      ex = ($urandom_range(0, 3) != 0);
      step($sformatf("rand%0d", i), l, r, s, lo, fw, ex, model(l, r, s, lo, fw));
    end

    // Mid-operation reset pulse shorter than a clock period, streaming ex=1.
    rand_ops(l, r, s);
    bus.l_s = l; bus.r_s = r; bus.s_s = s;
    bus.lohipass = 1'b1; bus.fwd_inv = 1'b1; bus.ex = 1'b1;
    @(posedge clk);
    #2 reset_l = 1'b0;
    #1;
    chk("mid_rst_res", {16'h0, bus.res_s}, 32'd0);
    chk("mid_rst_q", {28'h0, q}, 32'd0);
    chk("mid_rst_o", {31'h0, rst_o}, 32'd1);
    @(negedge clk);
    reset_l = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rel_e1_rst_o", {31'h0, rst_o}, 32'd1);
    chk("rel_e1_res", {16'h0, bus.res_s}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("rel_e2_rst_o", {31'h0, rst_o}, 32'd0);
    chk("rel_e2_res", {16'h0, bus.res_s}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("rel_e3_res", {16'h0, bus.res_s}, {16'h0, model(l, r, s, 1'b1, 1'b1)});
    chk("rel_e3_q", {28'h0, q}, 32'd1);
    last_exp = model(l, r, s, 1'b1, 1'b1);

    step("post_rst", -16'sd8, 16'sd4, 16'sd50, !HIPASS, FWD, 1'b1, 16'd49);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
